// File: rtl/scs8hd_o32a_sched_pkg.sv
// Shared types and helpers for the o32a round-robin scheduler.
// The state encoding is visible on the top's state_dbg port.
package scs8hd_o32a_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = 8;

  // X = (A1|A2|A3) & (B1|B2); only these five operand bits exist
  function automatic logic o32a_eval(input logic [2:0] a, input logic [1:0] b);
    return (|a) & (|b);
  endfunction

endpackage

// File: rtl/scs8hd_o32a_rr_arb.sv
// Round-robin arbiter: the first set req at index ptr, ptr+1, ... (mod N) wins.
// With en low, grant is all-zero and any is low.
module scs8hd_o32a_rr_arb
  import scs8hd_o32a_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // First pass covers ptr..N-1; second pass covers the wrapped part 0..ptr-1
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (en && !any && (i >= int'(ptr)) && req[i]) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (en && !any && (i < int'(ptr)) && req[i]) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
  end

endmodule

// File: rtl/scs8hd_o32a_sched.sv
// Shares one registered o32a evaluator among NREQ requesters.
// Request channel: a transfer happens on an edge where req_valid[i] & req_ready[i]; response channel: where rsp_valid & rsp_ready.
module scs8hd_o32a_sched
  import scs8hd_o32a_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              CLK,
  input  logic              RESET_B,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_a,
  input  logic [2*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_x,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy,
  output logic [CNT_W-1:0]  done_cnt,
  output logic [1:0]        state_dbg,
  output logic [IDW-1:0]    ptr_dbg
);

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr, gidx, id_q;
  logic [2:0]       op_a, sel_a;
  logic [1:0]       op_b, sel_b;
  logic             x_q;
  logic [CNT_W-1:0] cnt_q;
  logic [NREQ-1:0]  grant;
  logic             accept, arb_en, rsp_fire;

  assign arb_en = (state == IDLE);

  scs8hd_o32a_rr_arb #(
    .N  (NREQ),
    .IW (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .en    (arb_en),
    .grant (grant),
    .idx   (gidx),
    .any   (accept)
  );

  assign req_ready = grant;

  // Operand mux driven by the one-hot grant keeps every select constant
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[3*i +: 3];
        sel_b = req_b[2*i +: 2];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    rsp_fire  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_nxt = EVAL;
      end
      EVAL: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      state <= IDLE;
      ptr   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      id_q  <= '0;
      x_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a <= sel_a;
        op_b <= sel_b;
        id_q <= gidx;
        ptr  <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
      end
      if (state == EVAL) x_q <= o32a_eval(op_a, op_b);
      if (rsp_fire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign rsp_x     = x_q;
  assign rsp_id    = id_q;
  assign done_cnt  = cnt_q;
  assign state_dbg = state;
  assign ptr_dbg   = ptr;

endmodule

// File: tb/tb_scs8hd_o32a_sched.sv
// Directed bench for scs8hd_o32a_sched (NREQ=4): a transaction-level model checked every
// cycle, plus a queue of hand-computed responses and literal checks of latency and counters.
module tb_scs8hd_o32a_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              CLK;
  logic              RESET_B;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_a;
  logic [2*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_x;
  logic [IDW-1:0]    rsp_id;
  logic              busy;
  logic [7:0]        done_cnt;
  logic [1:0]        state_dbg;
  logic [IDW-1:0]    ptr_dbg;

  scs8hd_o32a_sched #(.NREQ(NREQ)) dut (
    .CLK       (CLK),
    .RESET_B   (RESET_B),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_x     (rsp_x),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .done_cnt  (done_cnt),
    .state_dbg (state_dbg),
    .ptr_dbg   (ptr_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit armed = 1'b0;
  bit track = 1'b1;
  logic [2:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // phase: 0 waiting for a grant, 1 computing, 2 response offered
  int         m_phase = 0;
  int         m_ptr   = 0;
  int         m_id    = 0;
  logic       m_x     = 1'b0;
  logic [7:0] m_cnt   = 8'd0;
  int         g_now;

  function automatic int rr_pick(input logic [3:0] v, input int p);
    logic [7:0] dbl;
    dbl = {v, v} >> p;
    for (int k = 0; k < 4; k++)
      if (dbl[k]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int g);
    logic [3:0] one;
    one = 4'b0001;
    if (g < 0) return 4'b0000;
    return one << g;
  endfunction

  always_comb g_now = rr_pick(req_valid, m_ptr);

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!RESET_B) begin
      m_phase <= 0;
      m_ptr   <= 0;
      m_cnt   <= 8'd0;
      m_x     <= 1'b0;
      m_id    <= 0;
    end else if (m_phase == 0) begin
      if (g_now >= 0) begin
        m_x     <= (req_a[3*g_now +: 3] != 3'd0) && (req_b[2*g_now +: 2] != 2'd0);
        m_id    <= g_now;
        m_ptr   <= (g_now + 1) % NREQ;
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      m_phase <= 2;
    end else if (rsp_ready) begin
      m_cnt   <= m_cnt + 8'd1;
      m_phase <= 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (armed) begin
      check("req_ready", req_ready, (m_phase == 0) ? onehot(g_now) : 4'b0000);
      check("rsp_valid", rsp_valid, m_phase == 2);
      check("busy", busy, m_phase != 0);
      check("done_cnt", done_cnt, m_cnt);
      check("ptr", ptr_dbg, m_ptr);
      if (m_phase == 2) begin
        check("model_rsp_x", rsp_x, m_x);
        check("model_rsp_id", rsp_id, m_id);
      end
    end
  end

  // ---------------- scoreboard on response handshakes ----------------
  always @(negedge CLK) begin
    if (armed && track && rsp_valid && rsp_ready && RESET_B) begin
      check("exp_q_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        logic [2:0] e;
        e = exp_q.pop_front();
        check("sb_rsp_x", rsp_x, e[2]);
        check("sb_rsp_id", rsp_id, e[1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET_B = 1'b0;
    step();
    RESET_B = 1'b1;
  endtask

  task automatic send(input int id, input logic [2:0] a, input logic [1:0] b);
    bit ok;
    ok = 1'b0;
    req_a[3*id +: 3] = a;
    req_b[2*id +: 2] = b;
    req_valid[id]    = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      if (req_ready[id]) begin
        ok = 1'b1;
        break;
      end
    end
    check("grant_timeout", ok, 1);
    step();
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(output int at);
    bit ok;
    ok = 1'b0;
    at = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      if (rsp_valid) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
    check("rsp_timeout", ok, 1);
  endtask

  task automatic run_one(input int id, input logic [2:0] a, input logic [1:0] b, input logic x);
    int at;
    exp_q.push_back({x, 2'(id)});
    send(id, a, b);
    wait_rsp(at);
    step();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int at, prev;
    logic       cap_x;
    logic [1:0] cap_id;
    RESET_B   = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (3) step();
    RESET_B = 1'b1;
    armed   = 1'b1;

    // reset state
    @(negedge CLK);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done_cnt", done_cnt, 0);
    check("rst_rsp_x", rsp_x, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_ptr", ptr_dbg, 0);

    // single request: latency of two edges
    rsp_ready = 1'b1;
    step();
    exp_q.push_back({1'b1, 2'd1});
    send(1, 3'b010, 2'b01);
    @(negedge CLK);
    check("lat_eval_rsp_valid", rsp_valid, 0);
    @(negedge CLK);
    check("lat_rsp_valid", rsp_valid, 1);
    check("single_rsp_x", rsp_x, 1);
    check("single_rsp_id", rsp_id, 1);
    step();
    check("single_done_cnt", done_cnt, 1);

    // zero-operand corners on requester 0
    run_one(0, 3'b000, 2'b11, 1'b0);
    run_one(0, 3'b100, 2'b00, 1'b0);
    run_one(0, 3'b001, 2'b10, 1'b1);
    check("zero_done_cnt", done_cnt, 4);

    // fairness: all valid from ptr=0, one response every 3 cycles
    do_reset();
    req_a = {3'd3, 3'd2, 3'd1, 3'd0};
    req_b = {2'd3, 2'd2, 2'd1, 2'd0};
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back({1'b0, 2'd0});
      exp_q.push_back({1'b1, 2'd1});
      exp_q.push_back({1'b1, 2'd2});
      exp_q.push_back({1'b1, 2'd3});
    end
    req_valid = 4'b1111;
    prev = 0;
    for (int r = 0; r < 12; r++) begin
      wait_rsp(at);
      check("fair_id", rsp_id, r % 4);
      if (r > 0) check("fair_spacing", at - prev, 3);
      prev = at;
      step();
    end
    req_valid = '0;
    check("fair_done_cnt", done_cnt, 12);

    // backpressure with other requesters waiting
    rsp_ready = 1'b0;
    req_a[3*1 +: 3] = 3'b111;
    req_b[2*1 +: 2] = 2'b10;
    req_a[3*3 +: 3] = 3'b000;
    req_b[2*3 +: 2] = 2'b01;
    exp_q.push_back({1'b1, 2'd1});
    exp_q.push_back({1'b0, 2'd3});
    req_valid = 4'b1010;
    wait_rsp(at);
    cap_x  = rsp_x;
    cap_id = rsp_id;
    check("bp_first_id", cap_id, 1);
    repeat (5) begin
      @(negedge CLK);
      check("bp_rsp_x_stable", rsp_x, cap_x);
      check("bp_rsp_id_stable", rsp_id, cap_id);
      check("bp_req_ready", req_ready, 0);
      check("bp_busy", busy, 1);
    end
    step();
    rsp_ready = 1'b1;
    step();
    wait_rsp(at);
    check("bp_next_id", rsp_id, 3);
    step();
    req_valid = '0;
    check("bp_done_cnt", done_cnt, 14);

    // reset while a response is held
    rsp_ready = 1'b0;
    send(2, 3'b100, 2'b01);
    wait_rsp(at);
    step();
    RESET_B = 1'b0;
    req_a[3*1 +: 3] = 3'b010;
    req_b[2*1 +: 2] = 2'b11;
    req_valid = 4'b1010;
    step();
    RESET_B = 1'b1;
    @(negedge CLK);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done_cnt", done_cnt, 0);
    check("mid_rst_ptr", ptr_dbg, 0);
    check("mid_rst_grant", req_ready, 4'b0010);
    exp_q.push_back({1'b1, 2'd1});
    step();
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_rsp(at);
    step();
    check("mid_rst_after_cnt", done_cnt, 1);

    // counter wrap over 256 responses
    do_reset();
    track = 1'b0;
    req_a[2:0] = 3'b001;
    req_b[1:0] = 2'b01;
    req_valid  = 4'b0001;
    for (int r = 0; r < 256; r++) begin
      wait_rsp(at);
      step();
      if (r == 254) check("wrap_255", done_cnt, 255);
      if (r == 255) check("wrap_0", done_cnt, 0);
    end
    req_valid = '0;
    step();
    check("exp_q_drained", exp_q.size(), 0);

    armed = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

endmodule
